// File: rtl/park_pkg.sv
// Shared types and helpers for the parking-lot controller slice.
// Tokens are 3-bit spot indices scrambled with a pattern XOR.
package park_pkg;

    localparam int SPOT_W    = 3;
    localparam int NUM_SPOTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        EXIT,
        RELEASE
    } park_state_t;

    // XOR is self-inverse, so this both encrypts and decrypts.
    function automatic logic [SPOT_W-1:0] park_xor(
        input logic [SPOT_W-1:0] token,
        input logic [SPOT_W-1:0] pattern
    );
        return token ^ pattern;
    endfunction

endpackage

// File: rtl/park_if.sv
// Gate-side entry/exit handshake bundle for the parking controller.
// master = gate request logic, slave = parking_controller.
interface park_if;
    import park_pkg::*;

    logic              enter_req;
    logic              enter_ack;
    logic              enter_rej;
    logic [SPOT_W-1:0] token_out;
    logic              exit_req;
    logic [SPOT_W-1:0] exit_token;
    logic              exit_ack;
    logic              exit_err;
    logic [SPOT_W-1:0] park_number;

    modport master (
        output enter_req, exit_req, exit_token,
        input  enter_ack, enter_rej, token_out,
        input  exit_ack, exit_err, park_number
    );

    modport slave (
        input  enter_req, exit_req, exit_token,
        output enter_ack, enter_rej, token_out,
        output exit_ack, exit_err, park_number
    );

endinterface

// File: rtl/park_free_finder.sv
// Lowest-free-spot priority encoder over the occupancy map.
// any_free is low when every spot is taken.
module park_free_finder
    import park_pkg::*;
(
    input  logic [NUM_SPOTS-1:0] occ_map,
    output logic [SPOT_W-1:0]    spot,
    output logic                 any_free
);

    always_comb begin
        spot     = '0;
        any_free = 1'b0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occ_map[i]) begin
                spot     = SPOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_controller.sv
// Entry/exit sequencer with 8-spot occupancy map and XOR tokens.
// Define PARK_EXIT_CHECK_EN to flag exits that decode to a free spot.
module parking_controller #(
    parameter int                          NUM_SPOTS   = 8,
    parameter logic [park_pkg::SPOT_W-1:0] PATTERN_RST = 3'b101
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_load,
    input  logic [park_pkg::SPOT_W-1:0]   cfg_pattern,
    park_if.slave                         bus,
    output logic                          lot_full,
    output logic [NUM_SPOTS-1:0]          occ_map
);
    import park_pkg::*;

    park_state_t          state;
    logic [SPOT_W-1:0]    pattern;
    logic [SPOT_W-1:0]    free_spot;
    logic [SPOT_W-1:0]    exit_spot;
    logic                 any_free;
    logic [NUM_SPOTS-1:0] occ_q;
    logic [NUM_SPOTS-1:0] occ_nxt;
    logic                 enter_ack_q;
    logic                 enter_rej_q;
    logic                 exit_ack_q;
    logic [SPOT_W-1:0]    token_q;
    logic [SPOT_W-1:0]    park_q;

    park_free_finder u_finder (
        .occ_map  (occ_q),
        .spot     (free_spot),
        .any_free (any_free)
    );

    assign exit_spot = park_xor(bus.exit_token, pattern);

    // Clearing an already-free bit is harmless, so exit always clears.
    always_comb begin
        occ_nxt = occ_q;
        unique case (state)
            ENTER:   if (any_free) occ_nxt[free_spot] = 1'b1;
            EXIT:    occ_nxt[exit_spot] = 1'b0;
            default: ;
        endcase
    end

`ifdef PARK_EXIT_CHECK_EN
    logic exit_err_q;
    assign bus.exit_err = exit_err_q;
`else
    assign bus.exit_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pattern     <= PATTERN_RST;
            occ_q       <= '0;
            lot_full    <= 1'b0;
            enter_ack_q <= 1'b0;
            enter_rej_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            token_q     <= '0;
            park_q      <= '0;
`ifdef PARK_EXIT_CHECK_EN
            exit_err_q  <= 1'b0;
`endif
        end else begin
            enter_ack_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            occ_q       <= occ_nxt;
            lot_full    <= &occ_nxt;
            unique case (state)
                IDLE: begin
                    if (bus.exit_req) begin
                        state <= EXIT;
                    end else if (bus.enter_req) begin
                        state <= ENTER;
                    end else if (cfg_load) begin
                        pattern <= cfg_pattern;
                    end
                end
                ENTER: begin
                    enter_ack_q <= 1'b1;
                    enter_rej_q <= !any_free;
                    if (any_free) begin
                        token_q <= park_xor(free_spot, pattern);
                    end
                    state <= RELEASE;
                end
                EXIT: begin
                    exit_ack_q <= 1'b1;
                    park_q     <= exit_spot;
`ifdef PARK_EXIT_CHECK_EN
                    exit_err_q <= !occ_q[exit_spot];
`endif
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!bus.enter_req && !bus.exit_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.enter_ack   = enter_ack_q;
    assign bus.enter_rej   = enter_rej_q;
    assign bus.token_out   = token_q;
    assign bus.exit_ack    = exit_ack_q;
    assign bus.park_number = park_q;
    assign occ_map         = occ_q;

endmodule
